// File: rtl/op_sub_serial.sv
// op_sub_serial: digit-serial a - b, W bits per cycle LSB first, with borrow/overflow flags over valid/ready
module op_sub_serial #(
  parameter int N = 8,
  parameter int W = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ov,
  output logic         uv,
  output logic         busy
);
  localparam int K = N / W;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  if (W < 1 || W > N || N % W != 0) begin : g_bad_params
    $error("op_sub_serial: N must be a multiple of W with 1 <= W <= N");
  end
  logic [1:0] state;
  logic [N-1:0] a_sh, b_sh, acc, acc_nx;
  logic [N+W-1:0] cat;
  logic [W:0] d;
  logic [CW-1:0] cnt;
  logic borrow, a_msb, b_msb, last;
  always_comb begin
    d = {1'b0, a_sh[W-1:0]} - {1'b0, b_sh[W-1:0]} - {{W{1'b0}}, borrow};
    cat = {d[W-1:0], acc};
    acc_nx = cat[N+W-1:W];
    last = cnt == CW'(K - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      result <= '0;
      ov <= 1'b0;
      uv <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      borrow <= 1'b0;
      cnt <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid && in_ready) begin
        a_sh <= a;
        b_sh <= b;
        a_msb <= a[N-1];
        b_msb <= b[N-1];
        borrow <= 1'b0;
        cnt <= '0;
        state <= RUN;
        in_ready <= 1'b0;
        busy <= 1'b1;
      end
    end else if (state == RUN) begin
      acc <= acc_nx;
      borrow <= d[W];
      a_sh <= a_sh >> W;
      b_sh <= b_sh >> W;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        out_valid <= 1'b1;
        result <= acc_nx;
        ov <= SIGNED & ~a_msb & b_msb & acc_nx[N-1];
        uv <= SIGNED ? (a_msb & ~b_msb & ~acc_nx[N-1]) : d[W];
      end
    end else if (out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      busy <= 1'b0;
    end
endmodule

// File: tb/tb_op_sub_serial.sv
// tb_op_sub_serial: scoreboard bench over W=1,2,4,8 in unsigned and signed modes
module tb_op_sub_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid[8], in_ready[8], out_valid[8], out_ready[8], busy[8], ov[8], uv[8];
  logic [7:0] a[8], b[8], result[8];
  logic [9:0] exp_q[8][$];
  logic [9:0] e;
  int checks = 0;
  int errors = 0;
  int lat;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 8; g++) begin : gi
    op_sub_serial #(.N(8), .W(1 << (g % 4)), .SIGNED(g / 4)) u (
      .clk(clk), .rst(rst), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a(a[g]), .b(b[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .result(result[g]), .ov(ov[g]), .uv(uv[g]), .busy(busy[g])
    );
  end
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input bit s);
    int df;
    logic o, u;
    if (s) begin
      df = int'($signed(x)) - int'($signed(y));
      o = df > 127;
      u = df < -128;
    end else begin
      df = int'(x) - int'(y);
      o = 1'b0;
      u = df < 0;
    end
    return {df[7:0], o, u};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  task automatic push(input int i, input logic [7:0] x, input logic [7:0] y);
    exp_q[i].push_back(model(x, y, i >= 4));
  endtask
  task automatic send(input int i, input logic [7:0] x, input logic [7:0] y, output int l);
    int k;
    a[i] = x;
    b[i] = y;
    in_valid[i] = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready[i]) break;
    end
    if (k == 50) chk("accept_timeout", 16'(k), 16'd0);
    @(posedge clk);
    push(i, x, y);
    #1 in_valid[i] = 1'b0;
    for (l = 0; l < 20 && !out_valid[i]; ) begin
      @(posedge clk);
      #1 l++;
    end
  endtask
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 8; i++)
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra%0d: got result %h with none expected", i, result[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("res%0d", i), {6'd0, result[i], ov[i], uv[i]}, {6'd0, e});
          end
        end
  initial begin
    int sent[8];
    bit acc[8];
    bit fin;
    logic [9:0] bp;
    for (int i = 0; i < 8; i++) begin
      in_valid[i] = 1'b0;
      a[i] = '0;
      b[i] = '0;
      out_ready[i] = 1'b1;
      sent[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      chk($sformatf("reset%0d", i), {3'd0, in_ready[i], out_valid[i], busy[i], result[i], ov[i], uv[i]}, 16'h1000);
    rst = 1'b0;
    send(1, 8'h35, 8'h12, lat); chk("lat_u1", 16'(lat), 16'd4);
    send(1, 8'h10, 8'h20, lat); chk("lat_u2", 16'(lat), 16'd4);
    send(1, 8'h00, 8'h01, lat); chk("lat_u3", 16'(lat), 16'd4);
    send(5, 8'h7F, 8'hFF, lat); chk("lat_s1", 16'(lat), 16'd4);
    send(5, 8'h80, 8'h01, lat); chk("lat_s2", 16'(lat), 16'd4);
    send(5, 8'h05, 8'h07, lat); chk("lat_s3", 16'(lat), 16'd4);
    send(3, 8'h05, 8'h09, lat); chk("lat_w8", 16'(lat), 16'd1);
    send(0, 8'hC3, 8'h3C, lat); chk("lat_w1", 16'(lat), 16'd8);
    @(posedge clk);
    #1 out_ready[1] = 1'b0;
    bp = model(8'hA7, 8'h3C, 1'b0);
    send(1, 8'hA7, 8'h3C, lat);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold%0d", k), {4'd0, out_valid[1], in_ready[1], result[1], ov[1], uv[1]}, {4'd0, 1'b1, 1'b0, bp});
      if (k == 4) begin
        in_valid[1] = 1'b1;
        a[1] = 8'h11;
        b[1] = 8'h22;
      end
      if (k == 5) in_valid[1] = 1'b0;
      @(posedge clk);
      #1;
    end
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1 chk("release", {14'd0, in_ready[1], out_valid[1]}, 16'h0002);
    a[1] = 8'h35;
    b[1] = 8'h12;
    in_valid[1] = 1'b1;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("midrun_rst", {3'd0, in_ready[1], out_valid[1], busy[1], result[1], ov[1], uv[1]}, 16'h1000);
    rst = 1'b0;
    fin = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 fin = fin | out_valid[1];
    end
    chk("no_ghost", 16'(fin), 16'd0);
    send(1, 8'h09, 8'h04, lat);
    @(posedge clk);
    #1;
    fin = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) acc[i] = in_valid[i] && in_ready[i];
      @(posedge clk);
      for (int i = 0; i < 8; i++)
        if (acc[i]) begin
          push(i, a[i], b[i]);
          sent[i]++;
        end
      #1 fin = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (acc[i] || !in_valid[i]) begin
          in_valid[i] = sent[i] < 100 && $urandom_range(0, 3) != 0;
          a[i] = 8'($urandom);
          b[i] = 8'($urandom);
        end
        out_ready[i] = sent[i] >= 100 || $urandom_range(0, 2) != 0;
        if (sent[i] < 100 || in_valid[i] || exp_q[i].size() != 0) fin = 1'b0;
      end
    end
    chk("stream_done", 16'(fin), 16'd1);
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("left%0d", i), 16'(exp_q[i].size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
